nn_result_axis_tx: RTL

//  AXI-Stream master that transmits one inference result from the final NN layer.

---
 rtl/nn_result_axis_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/nn_result_axis_tx.sv
// AXI-Stream master serialising one final-layer result vector (+ optional argmax beat) per frame.
// Latency: first beat valid 1 clock after i_valid; beats hold stable under tready backpressure.
module nn_result_axis_tx #(
  parameter int NUM_OUT      = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int TDATA_WIDTH  = 32,
  parameter int CLASS_WIDTH  = 32,
  parameter bit APPEND_CLASS = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [NUM_OUT*DATA_WIDTH-1:0] i_data,
  input  logic                          i_class_valid,
  input  logic [CLASS_WIDTH-1:0]        i_class,
  input  logic                          i_clr_overrun,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          o_busy,
  output logic                          o_overrun
);

  localparam int CW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OUT - 1);

  typedef enum logic [1:0] {IDLE, SEND_DATA, WAIT_CLASS, SEND_CLASS} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NUM_OUT*DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CLASS_WIDTH-1:0]        class_q, class_d;
  logic                          cap_q, cap_d;
  logic [TDATA_WIDTH-1:0]        tdata_q, tdata_d;
  logic                          tlast_q, tlast_d;
  logic                          ovr_q, ovr_d;

  logic                          hs;
  logic                          last_beat;
  logic                          final_hs;
  logic                          accept;
  logic                          cap_now;
  logic [CLASS_WIDTH-1:0]        class_now;

  function automatic logic [TDATA_WIDTH-1:0] sext_elem(
    input logic [NUM_OUT*DATA_WIDTH-1:0] vec,
    input int                            idx
  );
    logic signed [DATA_WIDTH-1:0] e;
    e = vec[idx*DATA_WIDTH +: DATA_WIDTH];
    return TDATA_WIDTH'(e);
  endfunction

  assign m_axis_tvalid = (state_q == SEND_DATA) || (state_q == SEND_CLASS);
  assign hs            = m_axis_tvalid && m_axis_tready;
  assign last_beat     = (cnt_q == LAST_IDX);
  assign final_hs      = hs && ((state_q == SEND_CLASS) ||
                                ((state_q == SEND_DATA) && last_beat && !APPEND_CLASS));
  // A new frame may start on the very handshake that completes the previous one.
  assign accept        = i_valid && ((state_q == IDLE) || final_hs);
  assign cap_now       = cap_q || i_class_valid;
  assign class_now     = i_class_valid ? i_class : class_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    class_d = class_q;
    cap_d   = cap_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    ovr_d   = ovr_q;

    case (state_q)
      SEND_DATA: begin
        if (hs) begin
          if (last_beat) begin
            tlast_d = 1'b0;
            if (!APPEND_CLASS) begin
              state_d = IDLE;
            end else if (cap_now) begin
              state_d = SEND_CLASS;
              tdata_d = TDATA_WIDTH'(class_now);
              tlast_d = 1'b1;
            end else begin
              state_d = WAIT_CLASS;
            end
          end else begin
            cnt_d   = cnt_q + CW'(1);
            tdata_d = sext_elem(hold_q, int'(cnt_q) + 1);
            tlast_d = !APPEND_CLASS && ((cnt_q + CW'(1)) == LAST_IDX);
          end
        end
      end
      WAIT_CLASS: begin
        if (i_class_valid) begin
          state_d = SEND_CLASS;
          tdata_d = TDATA_WIDTH'(i_class);
          tlast_d = 1'b1;
        end
      end
      SEND_CLASS: begin
        if (hs) begin
          state_d = IDLE;
          tlast_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      state_d = SEND_DATA;
      cnt_d   = '0;
      hold_d  = i_data;
      cap_d   = 1'b0;
      tdata_d = sext_elem(i_data, 0);
      tlast_d = !APPEND_CLASS && (NUM_OUT == 1);
    end

    // Class beat is taken from tdata_q, so re-capturing while it is presented is harmless.
    if (i_class_valid && ((state_q != IDLE) || i_valid)) begin
      class_d = i_class;
      cap_d   = 1'b1;
    end

    if (i_valid && !accept) begin
      ovr_d = 1'b1;
    end else if (i_clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      class_q <= '0;
      cap_q   <= 1'b0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      class_q <= class_d;
      cap_q   <= cap_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_axis_tdata = tdata_q;
  assign m_axis_tlast = tlast_q;
  assign o_busy       = (state_q != IDLE);
  assign o_overrun    = ovr_q;

endmodule
